lsu_nibble: RTL

- Load/store unit sitting directly upstream of the 256 x 4-bit data memory; the only block that drives its we/address/write_data and samples its read_data.
- Accepts one CPU request at a time over a valid/ready handshake.
- Sequences a single-nibble access or a two-nibble (8-bit pair) access to consecutive addresses.
- Returns the result over a valid/ready response channel.

---
 rtl/lsu_nibble.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lsu_nibble.sv
// Load/store unit in front of a 2^ADDR_W x DATA_W data memory: one request at a time, single or two-nibble access.
// Optional macro LSU_STATS_EN adds saturating load/store request counters (ld_count, st_count).
module lsu_nibble #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_pair,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_rdata,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]           ld_count,
  output logic [15:0]           st_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_rdy;
  logic                  r_we;
  logic                  r_pair;
  logic [2*DATA_W-1:0]   r_wdata;
  logic [2*DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  w_accept;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // r_rdy keeps req_ready low while reset is held and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = r_rdy;
        w_accept  = req_valid && r_rdy;
        if (w_accept) w_next = S_ACC0;
      end
      S_ACC0: begin
        mem_we = r_we;
        w_next = r_pair ? S_ACC1 : S_RESP;
      end
      S_ACC1: begin
        mem_we = r_we;
        w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Memory address/data are registered so they hold their last value outside the access states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_pair      <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_pair      <= req_pair;
            r_wdata     <= req_wdata;
            r_rdata     <= '0;
            r_mem_addr  <= req_addr;
            r_mem_wdata <= req_wdata[DATA_W-1:0];
          end
        end
        S_ACC0: begin
          if (!r_we) r_rdata[DATA_W-1:0] <= mem_rdata;
          if (r_pair) begin
            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
            r_mem_wdata <= r_wdata[2*DATA_W-1:DATA_W];
          end
        end
        S_ACC1: begin
          if (!r_we) r_rdata[2*DATA_W-1:DATA_W] <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_rdata = r_rdata;

`ifdef LSU_STATS_EN
  logic [15:0] r_ld_count;
  logic [15:0] r_st_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_count <= '0;
      r_st_count <= '0;
    end else if (w_accept) begin
      if (req_we) r_st_count <= sat_inc(r_st_count);
      else        r_ld_count <= sat_inc(r_ld_count);
    end
  end

  assign ld_count = r_ld_count;
  assign st_count = r_st_count;
`endif

endmodule
